seq_divider: RTL and testbench

- Iterative signed two's-complement divider for the ALU datapath.
- Performs the inverse of the adder path: repeated restoring subtraction, one quotient bit per clock.
- Accepts one operation on a start pulse, runs for a fixed latency, then presents quotient, remainder and exception flag with a one-cycle data_ready strobe.
- Sits beside the ALU adder/subtractor. The result mux selects it for DIV ops.

---
 rtl/seq_divider.sv | 134 +++++++++++++
 tb/tb_seq_divider.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Signed restoring divider: one quotient bit per clock, fixed WIDTH+1 latency.
// In: clock, reset, start, dividend, divisor. Out: busy, data_ready, quotient, remainder, div_by_zero.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             data_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_accept;
  logic   w_last;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_qw;
  logic [WIDTH-1:0] r_dmag;
  logic             r_sq;
  logic             r_sr;
  logic             r_dz;
  logic             r_busy;
  logic             r_dr;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_dzo;

  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_keep;

  // Most-negative input negates to itself, which reads as 2^(WIDTH-1) unsigned.
  assign w_dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign w_dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;

  assign w_shift = {r_rem, r_qw[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_dmag};
  assign w_keep  = ~w_trial[WIDTH];
  assign w_last  = (r_cnt == LAST);

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_qw   <= '0;
      r_dmag <= '0;
      r_sq   <= 1'b0;
      r_sr   <= 1'b0;
      r_dz   <= 1'b0;
      r_busy <= 1'b0;
      r_dr   <= 1'b0;
      r_quot <= '0;
      r_remo <= '0;
      r_dzo  <= 1'b0;
    end else begin
      r_dr   <= 1'b0;
      // Stays high through the data_ready cycle, which follows DONE.
      r_busy <= (r_state != S_IDLE) || w_accept;
      if (w_accept) begin
        r_dmag <= w_dvs_mag;
        r_qw   <= w_dvd_mag;
        r_rem  <= '0;
        r_sq   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        r_sr   <= dividend[WIDTH-1];
        r_dz   <= (divisor == '0);
        r_cnt  <= '0;
      end
      if (r_state == S_RUN) begin
        r_rem <= w_keep ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
        r_qw  <= {r_qw[WIDTH-2:0], w_keep};
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == S_DONE) begin
        r_dr <= 1'b1;
        if (r_dz) begin
          r_quot <= '0;
          r_remo <= '0;
          r_dzo  <= 1'b1;
        end else begin
          r_quot <= r_sq ? -r_qw : r_qw;
          r_remo <= r_sr ? -r_rem : r_rem;
          r_dzo  <= 1'b0;
        end
      end
    end
  end

  assign busy        = r_busy;
  assign data_ready  = r_dr;
  assign quotient    = r_quot;
  assign remainder   = r_remo;
  assign div_by_zero = r_dzo;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: arithmetic reference model plus directed vectors.
// Drives operands/handshake, checks every cycle and literal results.
module tb_seq_divider;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         data_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_divider #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .data_ready(data_ready),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  bit           m_valid = 1'b0;
  bit           m_active = 1'b0;
  longint       m_acc = 0;
  longint       n_edge = 0;
  bit           done_now;
  bit           acc;
  logic [W-1:0] m_a, m_b;
  logic [W-1:0] exp_q, exp_r;
  logic         exp_dz, exp_busy, exp_dr;

  function automatic void ref_div(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
    output logic         dz
  );
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      q = '0;
      r = '0;
      dz = 1'b1;
    end else begin
      q = W'(sa / sb);
      r = W'(sa % sb);
      dz = 1'b0;
    end
  endfunction

  // Timing model: accept in idle, result WIDTH+1 edges later, busy through it.
  always @(posedge clock) begin
    n_edge++;
    if (reset) begin
      m_valid  = 1'b1;
      m_active = 1'b0;
      exp_q    = '0;
      exp_r    = '0;
      exp_dz   = 1'b0;
      exp_busy = 1'b0;
      exp_dr   = 1'b0;
    end else if (m_valid) begin
      done_now = m_active && (n_edge - m_acc == W + 1);
      acc      = !m_active && start;
      exp_dr   = done_now;
      if (done_now) begin
        ref_div(m_a, m_b, exp_q, exp_r, exp_dz);
        m_active = 1'b0;
      end
      if (acc) begin
        m_active = 1'b1;
        m_acc    = n_edge;
        m_a      = dividend;
        m_b      = divisor;
      end
      exp_busy = acc || done_now || m_active;
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      n_vec++;
      if ({busy, data_ready} !== {exp_busy, exp_dr}) begin
        n_bad++;
        $display("FAIL hs t=%0t busy,dr=%b%b want %b%b",
                 $time, busy, data_ready, exp_busy, exp_dr);
      end
      n_vec++;
      if ({quotient, remainder, div_by_zero} !== {exp_q, exp_r, exp_dz}) begin
        n_bad++;
        $display("FAIL res t=%0t q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                 $time, quotient, remainder, div_by_zero, exp_q, exp_r, exp_dz);
      end
    end
  end

  task automatic run_op(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [W-1:0] eq,
    input logic [W-1:0] er,
    input logic         edz,
    input bit           intr,
    input string        nm
  );
    int lat;
    bit seen;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clock);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
      if (data_ready) seen = 1'b1;
      start = intr && !seen && (lat == 10 || lat == 32);
      if (start) begin
        dividend = 32'h7fff_0000;
        divisor  = 32'd3;
      end
    end
    start = 1'b0;
    n_vec++;
    if (!seen || lat != W + 1) begin
      n_bad++;
      $display("FAIL %s latency got %0d want %0d", nm, lat, W + 1);
    end
    n_vec++;
    if (quotient !== eq || remainder !== er || div_by_zero !== edz) begin
      n_bad++;
      $display("FAIL %s got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
               nm, quotient, remainder, div_by_zero, eq, er, edz);
    end
  endtask

  initial begin
    time t1;
    bit  any_dr;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    n_vec++;
    if ({busy, data_ready, quotient, remainder, div_by_zero} !== '0) begin
      n_bad++;
      $display("FAIL reset_state got busy=%b dr=%b q=%h r=%h dz=%b want all 0",
               busy, data_ready, quotient, remainder, div_by_zero);
    end

    run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, "100/7");
    run_op(-32'd100, 32'd7, -32'd14, -32'd2, 1'b0, 1'b0, "-100/7");
    run_op(32'd100, -32'd7, -32'd14, 32'd2, 1'b0, 1'b0, "100/-7");
    run_op(-32'd100, -32'd7, 32'd14, -32'd2, 1'b0, 1'b0, "-100/-7");
    run_op(32'd55, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, "55/0");
    run_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, "9/3");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b0, "min/-1");
    run_op(32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 1'b0, "min/1");
    run_op(32'd7, 32'd9, 32'd0, 32'd7, 1'b0, 1'b0, "7/9");
    run_op(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b1, "ignore_start");
    t1 = $time;
    run_op(32'd200, -32'd3, -32'd66, 32'd2, 1'b0, 1'b0, "back2back");
    n_vec++;
    if ($time - t1 != 340) begin
      n_bad++;
      $display("FAIL b2b_gap got %0t want 340", $time - t1);
    end

    repeat (3) @(posedge clock);
    #1;
    start    = 1'b1;
    dividend = 32'd500;
    divisor  = 32'd4;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    n_vec++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_busy got %b want 0", busy);
    end
    any_dr = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (data_ready) any_dr = 1'b1;
    end
    n_vec++;
    if (any_dr) begin
      n_bad++;
      $display("FAIL abort_no_dr got pulse want none");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
